usb_ep_pmod_bridge: RTL and testbench
=====================================

Name: usb_ep_pmod_bridge

Overview:
- Command bridge between one USB OUT endpoint FIFO, one USB IN endpoint FIFO and NUM_PORTS 8-bit Pmod ports on the board top level.
- Host sends byte commands over the OUT endpoint to write, read back or pulse individual Pmod ports; readback bytes return over the IN endpoint.
- Generalises fixed JA..JD registers to a parametrised port count with a handshaked, backpressure-aware command FSM.

Parameters:
NUM_PORTS, 4, number of 8-bit Pmod ports (1..64)
RESET_VAL, 8'h00, value every pmod_out byte takes at reset
PULSE_LEN, 16, clk cycles a PULSE value is held (>=1; used only with USB_PMOD_PULSE_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
ep_out_dout  in  8  OUT endpoint FIFO read data, valid the cycle after ep_out_re
ep_out_re  out  1  OUT FIFO read strobe, one cycle per byte
ep_out_empty  in  1  OUT FIFO empty
ep_in_din  out  8  IN endpoint FIFO write data
ep_in_we  out  1  IN FIFO write strobe, one cycle per byte
ep_in_full  in  1  IN FIFO full
pmod_in  in  NUM_PORTS*8  sampled pin levels, byte k = port k
pmod_out  out  NUM_PORTS*8  registered port drive, byte k = port k
err_cnt  out  8  saturating illegal-command count
busy  out  1  FSM not IDLE or pulse active

Behaviour:
- Reset (reset=0, async): pmod_out = {NUM_PORTS{RESET_VAL}}, ep_out_re=0, ep_in_we=0, ep_in_din=0, err_cnt=0, busy=0, FSM IDLE, pulse inactive; partially read command discarded.
- Header byte: [7:6] op (00 WRITE, 01 READ, 10 PULSE, 11 illegal), [5:0] port index. WRITE/PULSE followed by one data byte; READ has none.
- All outputs registered. ep_out_re asserted only when ep_out_empty was 0 in the previous cycle.
- FSM states: IDLE, HDR_RD, HDR_CAP, DAT_REQ, DAT_RD, DAT_CAP, RESP.
- IDLE: ep_out_empty=0 -> HDR_RD (ep_out_re=1 that cycle). HDR_RD -> HDR_CAP. HDR_CAP: latch header; WRITE/PULSE -> DAT_REQ; READ -> RESP; op 11 -> IDLE, err_cnt+1.
- Port index >= NUM_PORTS: error flagged; WRITE/PULSE still consume data byte (discarded), READ sends nothing; err_cnt+1 once per command.
- DAT_REQ: wait ep_out_empty=0 -> DAT_RD (ep_out_re=1). DAT_RD -> DAT_CAP. DAT_CAP: apply data; pmod_out byte updates on the next edge; -> IDLE.
- Latency: header and data both in FIFO, IDLE at cycle N -> new pmod_out visible cycle N+6.
- RESP: hold while ep_in_full=1; else ep_in_we=1 one cycle, ep_in_din = pmod_in byte sampled that cycle -> IDLE.
- err_cnt saturates at 8'hFF.
- Reset mid-command: no pmod_out change from the aborted command; next byte read after reset is treated as a header.

Optional Feature:
USB_PMOD_PULSE_EN
- Defined: PULSE drives the data byte on the port for exactly PULSE_LEN cycles, then restores the prior value. Down-counter plus saved port index/value. One pulse active at a time: a new PULSE stalls in DAT_CAP until the active pulse restores. A WRITE to the pulsing port cancels the pulse; the written value stands. busy=1 while the pulse is active.
- Undefined: op 10 is illegal: data byte consumed, err_cnt+1, no port change. No counter logic.

Test Plan:
- NUM_PORTS=4, OUT FIFO {8'h02,8'hA5} -> pmod_out[23:16]=8'hA5 at cycle N+6; other bytes stay 8'h00; exactly 2 ep_out_re pulses.
- pmod_in[15:8]=8'h3C, OUT {8'h41} -> single ep_in_we with ep_in_din=8'h3C.
- Same READ with ep_in_full=1 for 20 cycles -> no ep_in_we, busy=1; ep_in_we one cycle after full drops.
- OUT {8'h07,8'hFF} (port 7 >= 4) then {8'hC0} -> pmod_out unchanged, err_cnt=2, 3 bytes consumed; 300 illegal headers -> err_cnt=8'hFF.
- USB_PMOD_PULSE_EN, PULSE_LEN=16, port 0 = 8'h11, OUT {8'h80,8'hF0} -> port 0 = 8'hF0 for exactly 16 cycles, then 8'h11; busy=1 throughout.
- reset low in DAT_RD of {8'h03,8'h55}, release, OUT {8'h01,8'h77} -> port 3 = RESET_VAL, port 1 = 8'h77.

Source files
------------

// File: rtl/usb_ep_pmod_bridge.sv
// USB endpoint command bridge driving NUM_PORTS 8-bit Pmod ports (write / read / pulse).
// Optional timed pulse command enabled by defining USB_PMOD_PULSE_EN.
module usb_ep_pmod_bridge #(
  parameter int         NUM_PORTS = 4,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter int         PULSE_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             ep_out_dout,
  output logic                   ep_out_re,
  input  logic                   ep_out_empty,
  output logic [7:0]             ep_in_din,
  output logic                   ep_in_we,
  input  logic                   ep_in_full,
  input  logic [NUM_PORTS*8-1:0] pmod_in,
  output logic [NUM_PORTS*8-1:0] pmod_out,
  output logic [7:0]             err_cnt,
  output logic                   busy
);

  // state     | meaning
  // S_IDLE    | wait for a header byte in the OUT FIFO
  // S_HDR_RD  | header read strobe issued
  // S_HDR_CAP | header on ep_out_dout, decode it
  // S_DAT_REQ | wait for the data byte
  // S_DAT_RD  | data read strobe issued
  // S_DAT_CAP | data on ep_out_dout (or held while a pulse stalls), apply it
  // S_RESP    | push readback byte once the IN FIFO has room
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_RD, S_HDR_CAP, S_DAT_REQ, S_DAT_RD, S_DAT_CAP, S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_PULSE = 2'b10;
  localparam logic [6:0] NP7      = 7'(NUM_PORTS);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  port_q, port_d;
  logic        ok_q, ok_d;
  logic [7:0]  data_q, data_d;
  logic        stall_q, stall_d;
  logic [7:0]  port_val_q [NUM_PORTS];
  logic [7:0]  port_val_d [NUM_PORTS];
  logic        ep_out_re_q, ep_out_re_d;
  logic        ep_in_we_q, ep_in_we_d;
  logic [7:0]  ep_in_din_q, ep_in_din_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        busy_q, busy_d;

  logic        err_inc;
  logic        hdr_in_rng;
  logic [7:0]  dat_byte;
  logic [7:0]  rd_byte;

`ifdef USB_PMOD_PULSE_EN
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  logic             pulse_act_q, pulse_act_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [5:0]       pulse_port_q, pulse_port_d;
  logic [7:0]       pulse_save_q, pulse_save_d;
  logic [7:0]       cur_val;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    port_d      = port_q;
    ok_d        = ok_q;
    data_d      = data_q;
    stall_d     = stall_q;
    port_val_d  = port_val_q;
    ep_out_re_d = 1'b0;
    ep_in_we_d  = 1'b0;
    ep_in_din_d = ep_in_din_q;
    err_inc     = 1'b0;
    hdr_in_rng  = ({1'b0, ep_out_dout[5:0]} < NP7);
    // once stalled, the FIFO data bus has moved on, so use the held copy
    dat_byte    = stall_q ? data_q : ep_out_dout;
    rd_byte     = 8'h00;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (port_q == 6'(k)) rd_byte = pmod_in[k*8 +: 8];
    end

`ifdef USB_PMOD_PULSE_EN
    pulse_act_d  = pulse_act_q;
    pulse_cnt_d  = pulse_cnt_q;
    pulse_port_d = pulse_port_q;
    pulse_save_d = pulse_save_q;
    cur_val      = 8'h00;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (port_q == 6'(k)) cur_val = port_val_q[k];
    end
    if (pulse_act_q) begin
      if (pulse_cnt_q == CNT_W'(1)) begin
        pulse_act_d = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (pulse_port_q == 6'(k)) port_val_d[k] = pulse_save_q;
        end
      end else begin
        pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
      end
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (!ep_out_empty) begin
          ep_out_re_d = 1'b1;
          state_d     = S_HDR_RD;
        end
      end
      S_HDR_RD: state_d = S_HDR_CAP;
      S_HDR_CAP: begin
        op_d   = ep_out_dout[7:6];
        port_d = ep_out_dout[5:0];
        case (ep_out_dout[7:6])
          OP_WRITE: begin
            ok_d    = hdr_in_rng;
            state_d = S_DAT_REQ;
          end
          OP_READ: begin
            ok_d    = hdr_in_rng;
            state_d = hdr_in_rng ? S_RESP : S_IDLE;
          end
          OP_PULSE: begin
`ifdef USB_PMOD_PULSE_EN
            ok_d    = hdr_in_rng;
`else
            ok_d    = 1'b0;
`endif
            state_d = S_DAT_REQ;
          end
          default: begin
            ok_d    = 1'b0;
            state_d = S_IDLE;
          end
        endcase
        err_inc = !ok_d;
      end
      S_DAT_REQ: begin
        if (!ep_out_empty) begin
          ep_out_re_d = 1'b1;
          state_d     = S_DAT_RD;
        end
      end
      S_DAT_RD: state_d = S_DAT_CAP;
      S_DAT_CAP: begin
        data_d  = dat_byte;
        stall_d = 1'b0;
        state_d = S_IDLE;
        if (ok_q && op_q == OP_WRITE) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_q == 6'(k)) port_val_d[k] = dat_byte;
          end
`ifdef USB_PMOD_PULSE_EN
          if (pulse_act_q && pulse_port_q == port_q) pulse_act_d = 1'b0;
`endif
        end
`ifdef USB_PMOD_PULSE_EN
        if (ok_q && op_q == OP_PULSE) begin
          if (pulse_act_q) begin
            stall_d = 1'b1;
            state_d = S_DAT_CAP;
          end else begin
            pulse_act_d  = 1'b1;
            pulse_cnt_d  = CNT_W'(PULSE_LEN);
            pulse_port_d = port_q;
            pulse_save_d = cur_val;
            for (int k = 0; k < NUM_PORTS; k++) begin
              if (port_q == 6'(k)) port_val_d[k] = dat_byte;
            end
          end
        end
`endif
      end
      S_RESP: begin
        if (!ep_in_full) begin
          ep_in_we_d  = 1'b1;
          ep_in_din_d = rd_byte;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
`ifdef USB_PMOD_PULSE_EN
    busy_d = (state_d != S_IDLE) || pulse_act_d;
`else
    busy_d = (state_d != S_IDLE);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      port_q      <= 6'd0;
      ok_q        <= 1'b0;
      data_q      <= 8'h00;
      stall_q     <= 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) port_val_q[k] <= RESET_VAL;
      ep_out_re_q <= 1'b0;
      ep_in_we_q  <= 1'b0;
      ep_in_din_q <= 8'h00;
      err_cnt_q   <= 8'h00;
      busy_q      <= 1'b0;
`ifdef USB_PMOD_PULSE_EN
      pulse_act_q  <= 1'b0;
      pulse_cnt_q  <= '0;
      pulse_port_q <= 6'd0;
      pulse_save_q <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      port_q      <= port_d;
      ok_q        <= ok_d;
      data_q      <= data_d;
      stall_q     <= stall_d;
      port_val_q  <= port_val_d;
      ep_out_re_q <= ep_out_re_d;
      ep_in_we_q  <= ep_in_we_d;
      ep_in_din_q <= ep_in_din_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
`ifdef USB_PMOD_PULSE_EN
      pulse_act_q  <= pulse_act_d;
      pulse_cnt_q  <= pulse_cnt_d;
      pulse_port_q <= pulse_port_d;
      pulse_save_q <= pulse_save_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign pmod_out[g*8 +: 8] = port_val_q[g];
  end

  assign ep_out_re = ep_out_re_q;
  assign ep_in_we  = ep_in_we_q;
  assign ep_in_din = ep_in_din_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb_ep_pmod_bridge.sv
// Directed self-checking bench for usb_ep_pmod_bridge (4 ports, PULSE_LEN 16).
module tb_usb_ep_pmod_bridge;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      ep_out_dout;
  logic            ep_out_re;
  logic            ep_out_empty;
  logic [7:0]      ep_in_din;
  logic            ep_in_we;
  logic            ep_in_full;
  logic [NP*8-1:0] pmod_in;
  logic [NP*8-1:0] pmod_out;
  logic [7:0]      err_cnt;
  logic            busy;

  int         checks = 0;
  int         errors = 0;
  int         re_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] last_din = 8'h00;
  logic [7:0] fifo [$];
  int         exp_err = 0;

  always #5 clk = ~clk;

  usb_ep_pmod_bridge #(.NUM_PORTS(NP), .RESET_VAL(8'h00), .PULSE_LEN(16)) dut (
    .clk(clk), .reset(reset),
    .ep_out_dout(ep_out_dout), .ep_out_re(ep_out_re), .ep_out_empty(ep_out_empty),
    .ep_in_din(ep_in_din), .ep_in_we(ep_in_we), .ep_in_full(ep_in_full),
    .pmod_in(pmod_in), .pmod_out(pmod_out), .err_cnt(err_cnt), .busy(busy)
  );

  // OUT FIFO model: data valid the cycle after the read strobe; IN FIFO sink counts writes
  always @(posedge clk) begin
    if (ep_out_re) begin
      re_cnt++;
      if (fifo.size() > 0) ep_out_dout <= fifo.pop_front();
      else ep_out_dout <= 8'hEE;
      ep_out_empty <= (fifo.size() == 0);
    end
    if (ep_in_we) begin
      we_cnt++;
      last_din = ep_in_din;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    ep_out_empty = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (!(fifo.size() == 0 && busy == 1'b0 && ep_out_re == 1'b0) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pmod_out !== 32'h0000_0000) begin errors++; $display("FAIL rst_pmod_out: got %h want 00000000", pmod_out); end
    checks++; if (ep_out_re !== 1'b0) begin errors++; $display("FAIL rst_ep_out_re: got %b want 0", ep_out_re); end
    checks++; if (ep_in_we !== 1'b0) begin errors++; $display("FAIL rst_ep_in_we: got %b want 0", ep_in_we); end
    checks++; if (ep_in_din !== 8'h00) begin errors++; $display("FAIL rst_ep_in_din: got %h want 00", ep_in_din); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_err_cnt: got %h want 00", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int re0 = re_cnt;
    push(8'h02); push(8'hA5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (pmod_out[23:16] !== 8'h00) begin errors++; $display("FAIL write_early: port2 got %h want 00 at N+5", pmod_out[23:16]); end
    @(negedge clk);
    checks++; if (pmod_out !== 32'h00A5_0000) begin errors++; $display("FAIL write_latency: got %h want 00a50000 at N+6", pmod_out); end
    wait_idle(30, "write");
    checks++; if (re_cnt - re0 !== 2) begin errors++; $display("FAIL write_re_count: got %0d want 2", re_cnt - re0); end
    checks++; if (pmod_out !== 32'h00A5_0000) begin errors++; $display("FAIL write_hold: got %h want 00a50000", pmod_out); end
  endtask

  task automatic test_read();
    int we0 = we_cnt;
    int n = 0;
    pmod_in = 32'h0000_3C00;
    push(8'h41);
    while (we_cnt == we0 && n < 20) begin @(negedge clk); n++; end
    wait_idle(30, "read");
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL read_we_count: got %0d want 1", we_cnt - we0); end
    checks++; if (last_din !== 8'h3C) begin errors++; $display("FAIL read_data: got %h want 3c", last_din); end
  endtask

  task automatic test_read_full();
    int we0 = we_cnt;
    ep_in_full = 1'b1;
    push(8'h41);
    repeat (20) @(negedge clk);
    checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL full_no_write: got %0d writes want 0", we_cnt - we0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
    pmod_in = 32'h0000_9600;
    ep_in_full = 1'b0;
    @(negedge clk);
    checks++; if (ep_in_we !== 1'b1) begin errors++; $display("FAIL full_release_we: got %b want 1", ep_in_we); end
    checks++; if (ep_in_din !== 8'h96) begin errors++; $display("FAIL full_release_din: got %h want 96", ep_in_din); end
    @(negedge clk);
    checks++; if (ep_in_we !== 1'b0) begin errors++; $display("FAIL full_single_we: got %b want 0", ep_in_we); end
    wait_idle(30, "read_full");
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL full_we_count: got %0d want 1", we_cnt - we0); end
  endtask

  task automatic test_errors();
    int re0 = re_cnt;
    push(8'h07); push(8'hFF); push(8'hC0);
    exp_err = exp_err + 2;
    wait_idle(40, "errors");
    checks++; if (pmod_out !== 32'h00A5_0000) begin errors++; $display("FAIL err_pmod: got %h want 00a50000", pmod_out); end
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL err_count: got %0d want %0d", err_cnt, exp_err); end
    checks++; if (re_cnt - re0 !== 3) begin errors++; $display("FAIL err_consumed: got %0d want 3", re_cnt - re0); end
  endtask

  task automatic test_op10_default();
    int re0 = re_cnt;
    push(8'h80); push(8'hF0);
    exp_err = exp_err + 1;
    wait_idle(40, "op10");
    checks++; if (pmod_out !== 32'h00A5_0000) begin errors++; $display("FAIL op10_pmod: got %h want 00a50000", pmod_out); end
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL op10_err: got %0d want %0d", err_cnt, exp_err); end
    checks++; if (re_cnt - re0 !== 2) begin errors++; $display("FAIL op10_consumed: got %0d want 2", re_cnt - re0); end
  endtask

  task automatic test_pulse();
    int n = 0;
    int len = 0;
    logic busy_ok = 1'b1;
    push(8'h00); push(8'h11);
    wait_idle(30, "pulse_setup");
    push(8'h80); push(8'hF0);
    while (pmod_out[7:0] !== 8'hF0 && n < 20) begin @(negedge clk); n++; end
    while (pmod_out[7:0] === 8'hF0 && len < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      len++;
    end
    checks++; if (len !== 16) begin errors++; $display("FAIL pulse_len: got %0d cycles want 16", len); end
    checks++; if (pmod_out[7:0] !== 8'h11) begin errors++; $display("FAIL pulse_restore: got %h want 11", pmod_out[7:0]); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL pulse_busy: got %b want 1", busy_ok); end
    wait_idle(40, "pulse");
  endtask

  task automatic test_err_saturate();
    int n = 254 - exp_err;
    for (int i = 0; i < n; i++) push(8'hC0);
    wait_idle(2000, "sat_a");
    checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL sat_fe: got %h want fe", err_cnt); end
    push(8'hC0);
    wait_idle(40, "sat_b");
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_ff: got %h want ff", err_cnt); end
    for (int i = 0; i < 300 - n - 1; i++) push(8'hC0);
    wait_idle(2000, "sat_c");
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", err_cnt); end
  endtask

  task automatic test_reset_mid();
    push(8'h03); push(8'h55);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (ep_out_re !== 1'b1) begin errors++; $display("FAIL mid_in_dat_rd: re got %b want 1", ep_out_re); end
    reset = 1'b0;
    fifo.delete();
    ep_out_empty = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pmod_out !== 32'h0000_0000) begin errors++; $display("FAIL mid_reset_pmod: got %h want 00000000", pmod_out); end
    reset = 1'b1;
    exp_err = 0;
    @(negedge clk);
    push(8'h01); push(8'h77);
    wait_idle(30, "mid");
    checks++; if (pmod_out !== 32'h0000_7700) begin errors++; $display("FAIL mid_after: got %h want 00007700", pmod_out); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL mid_err: got %h want 00", err_cnt); end
  endtask

  initial begin
    reset        = 1'b0;
    ep_out_empty = 1'b1;
    ep_out_dout  = 8'h00;
    ep_in_full   = 1'b0;
    pmod_in      = '0;
    test_reset();
    test_write();
    test_read();
    test_read_full();
    test_errors();
`ifdef USB_PMOD_PULSE_EN
    test_pulse();
    push(8'h00); push(8'h00);
    wait_idle(30, "pulse_clear");
`else
    test_op10_default();
`endif
    test_err_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
